// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage MIPS pipeline.
//
// Drives the load enables and flush/bubble controls of the PC, IF/ID, ID/EX
// and EX/MEM registers. It handles three cases: load-use hazards, redirects
// from a taken branch or jump that is resolved in MEM, and multi-cycle
// data-memory waits, which abort after MEM_TIMEOUT cycles. It also keeps two
// saturating performance counters.
//
// Parameters:
//   MEM_TIMEOUT  wait cycles without mem_ready before the access is abandoned (1..255)
//   CNT_W        performance counter width
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   id_rs, id_rt, id_uses_rt    source registers of the instruction in ID
//   ex_mem_read, ex_rt          load destination held in ID/EX
//   mem_branch_taken, mem_jump  redirect requests from MEM
//   mem_access, mem_ready       data-memory handshake
//   pc_write, ifid_write        load enables
//   ifid_flush, idex_bubble, exmem_flush, pipe_hold   pipeline controls
//   mem_error                   sticky memory-timeout flag
//   stall_cycles, flush_events  saturating performance counters
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_jump,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_hold,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(MEM_TIMEOUT);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state;
    logic [TW-1:0] timer;

    logic memWaitReq;
    logic timedOut;
    logic holdNow;
    logic redirect;
    logic loadUse;
    logic applyRedirect;

    assign memWaitReq = mem_access & ~mem_ready;
    assign timedOut   = (state == MEM_WAIT) & ~mem_ready & (timer >= TIMEOUT_V);

    // The final timeout cycle counts as completion, so the hold releases there.
    assign holdNow = (state == RUN) ? memWaitReq : (~mem_ready & ~timedOut);

    assign redirect = mem_branch_taken | mem_jump;

    // Register 0 never creates a dependence.
    assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // While memory is pending, a redirect is deferred. A redirect also
    // overrides a load-use stall, because the instruction in ID is flushed.
    assign applyRedirect = rst_n & ~holdNow & redirect;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (holdNow) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (redirect) begin
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (loadUse) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            timer        <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (applyRedirect && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
            case (state)
                RUN: begin
                    if (memWaitReq) begin
                        state <= MEM_WAIT;
                        timer <= TW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                        timer <= '0;
                    end else if (timedOut) begin
                        mem_error <= 1'b1;
                        state     <= RUN;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule
